// File: rtl/fir_stream_filter_pkg.sv
// Shared constants and elaboration-time helpers for the streaming FIR filter.
// Covers the clog2 helper, the accumulator-width and latency formulas,
// the unity coefficient (1.0 = 2**FRAC_BITS) and the legal tap-count check.
package fir_stream_filter_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int COEF_W_DEF    = 16;
  localparam int FRAC_BITS_DEF = 14;
  localparam int TAPS_DEF      = 16;

  // Ceiling log2 for elaboration-time sizing (value >= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Adder-tree output width: full product width plus one bit per tree level.
  function automatic int acc_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + clog2(taps);
  endfunction

  // Input-to-output latency: delay line, product, tree levels, round/narrow.
  function automatic int lat(input int taps);
    return 3 + clog2(taps);
  endfunction

  // Fixed-point 1.0 for the given number of fractional bits.
  function automatic int coef_one(input int frac_bits);
    return 32'sd1 <<< frac_bits;
  endfunction

  // Tap count must be a power of two between 2 and 64.
  function automatic bit taps_ok(input int taps);
    return (taps >= 32'sd2) && (taps <= 32'sd64) && ((taps & (taps - 32'sd1)) == 32'sd0);
  endfunction

  localparam int COEF_ONE = 32'sd1 <<< FRAC_BITS_DEF;

endpackage

// File: rtl/fir_stream_filter_if.sv
// Sample stream bundle of the FIR filter: playback samples in, filtered
// samples out. sat_flag exists only when FIR_SATURATE_EN is defined.
interface fir_stream_filter_if #(
  parameter int DATA_W = 32
) ();

  logic                     in_valid;
  logic signed [DATA_W-1:0] in_sample;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_sample;
`ifdef FIR_SATURATE_EN
  logic                     sat_flag;
`endif

  // Sample source / result sink side.
  modport master (
    output in_valid,
    output in_sample,
    input  out_valid,
    input  out_sample
`ifdef FIR_SATURATE_EN
    ,
    input  sat_flag
`endif
  );

  // Filter side.
  modport slave (
    input  in_valid,
    input  in_sample,
    output out_valid,
    output out_sample
`ifdef FIR_SATURATE_EN
    ,
    output sat_flag
`endif
  );

endinterface

// File: rtl/fir_stream_filter_adder_tree.sv
// Registered pairwise reduction of TAPS signed operands, one tree level per
// clock, with the qualifying valid bit carried alongside. Nodes are kept in
// heap order: node n sums children 2n and 2n+1; indices TAPS..2*TAPS-1 are
// the sign-extended leaves, node 1 is the root.
module fir_adder_tree
  import fir_stream_filter_pkg::*;
#(
  parameter int TAPS = 16,
  parameter int IN_W = 48
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic signed [IN_W-1:0]                in_data [TAPS],
  output logic                                  out_valid,
  output logic signed [IN_W+clog2(TAPS)-1:0]    out_data
);

  localparam int LVLS  = clog2(TAPS);
  localparam int OUT_W = IN_W + LVLS;

  logic signed [OUT_W-1:0] node_r [1:TAPS-1];
  logic signed [OUT_W-1:0] all_s  [1:2*TAPS-1];
  logic        [LVLS-1:0]  valid_r;

  // Flatten registered nodes and sign-extended leaves into one heap view.
  always_comb begin
    for (int n = 1; n < 2 * TAPS; n++) begin
      all_s[n] = '0;
    end
    for (int n = 1; n < TAPS; n++) begin
      all_s[n] = node_r[n];
    end
    for (int i = 0; i < TAPS; i++) begin
      all_s[TAPS + i] = OUT_W'(in_data[i]);
    end
  end

  // Every internal node registers the sum of its two children.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 1; n < TAPS; n++) begin
        node_r[n] <= '0;
      end
    end else begin
      for (int n = 1; n < TAPS; n++) begin
        node_r[n] <= all_s[2 * n] + all_s[2 * n + 1];
      end
    end
  end

  // Valid shift register matching the tree depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
    end else begin
      valid_r[0] <= in_valid;
      for (int l = 1; l < LVLS; l++) begin
        valid_r[l] <= valid_r[l-1];
      end
    end
  end

  assign out_valid = valid_r[LVLS-1];
  assign out_data  = node_r[1];

endmodule

// File: rtl/fir_stream_filter.sv
// Streaming FIR filter between capture-RAM playback and result-RAM write.
// One signed sample in per in_valid, one filtered sample out LAT = 3+clog2(TAPS)
// cycles later. Coefficients are runtime-writable; reset loads a unit impulse.
// Optional build macro FIR_SATURATE_EN: clamp the rounded result to DATA_W
// and report clamping on sat_flag; otherwise the result wraps to DATA_W bits.
module fir_stream_filter
  import fir_stream_filter_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int COEF_W    = COEF_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int TAPS      = TAPS_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     coef_we,
  input  logic [clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  fir_stream_filter_if.slave       strm
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);

  localparam logic signed [COEF_W-1:0] COEF_ONE_C = COEF_W'(coef_one(FRAC_BITS));
  localparam logic signed [ACC_W-1:0]  RND_C      = ACC_W'(coef_one(FRAC_BITS - 1));

  if (!taps_ok(TAPS)) begin : g_bad_taps
    $error("fir_stream_filter: TAPS must be a power of two in 2..64");
  end

  logic signed [DATA_W-1:0] x_r    [TAPS];
  logic signed [COEF_W-1:0] coef_r [TAPS];
  logic signed [PROD_W-1:0] p_r    [TAPS];
  logic                     x_valid_r;
  logic                     p_valid_r;
  logic                     tree_valid_s;
  logic signed [ACC_W-1:0]  tree_sum_s;
  logic signed [ACC_W-1:0]  rnd_s;
  logic signed [DATA_W-1:0] narrow_s;
  logic signed [DATA_W-1:0] out_sample_r;
  logic                     out_valid_r;
`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX_C =
    $signed({{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN_C = ~SAT_MAX_C;
  logic sat_s;
  logic sat_flag_r;
`endif

  // Delay line: shift on accepted samples, clr zeroes history (new sample still lands in x[0]).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        x_r[k] <= '0;
      end
      x_valid_r <= 1'b0;
    end else begin
      if (clr) begin
        for (int k = 0; k < TAPS; k++) begin
          x_r[k] <= '0;
        end
        if (strm.in_valid) begin
          x_r[0] <= strm.in_sample;
        end
      end else if (strm.in_valid) begin
        x_r[0] <= strm.in_sample;
        for (int k = 1; k < TAPS; k++) begin
          x_r[k] <= x_r[k-1];
        end
      end
      x_valid_r <= strm.in_valid;
    end
  end

  // Coefficient bank: unit impulse after reset, single-tap writes afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        coef_r[k] <= (k == 0) ? COEF_ONE_C : '0;
      end
    end else if (coef_we) begin
      coef_r[coef_addr] <= coef_data;
    end
  end

  // Full-precision per-tap products; bubbles flow through unqualified.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        p_r[k] <= '0;
      end
      p_valid_r <= 1'b0;
    end else begin
      for (int k = 0; k < TAPS; k++) begin
        p_r[k] <= PROD_W'(x_r[k]) * PROD_W'(coef_r[k]);
      end
      p_valid_r <= x_valid_r;
    end
  end

  fir_adder_tree #(
    .TAPS (TAPS),
    .IN_W (PROD_W)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (p_valid_r),
    .in_data   (p_r),
    .out_valid (tree_valid_s),
    .out_data  (tree_sum_s)
  );

  // Round half up to integer, then narrow to the sample width (clamp or wrap).
  always_comb begin
    rnd_s = (tree_sum_s + RND_C) >>> FRAC_BITS;
`ifdef FIR_SATURATE_EN
    if (rnd_s > SAT_MAX_C) begin
      narrow_s = DATA_W'(SAT_MAX_C);
      sat_s    = 1'b1;
    end else if (rnd_s < SAT_MIN_C) begin
      narrow_s = DATA_W'(SAT_MIN_C);
      sat_s    = 1'b1;
    end else begin
      narrow_s = DATA_W'(rnd_s);
      sat_s    = 1'b0;
    end
`else
    narrow_s = DATA_W'(rnd_s);
`endif
  end

  // Output register: capture qualified results, hold the last one across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_sample_r <= '0;
      out_valid_r  <= 1'b0;
`ifdef FIR_SATURATE_EN
      sat_flag_r   <= 1'b0;
`endif
    end else begin
      out_valid_r <= tree_valid_s;
      if (tree_valid_s) begin
        out_sample_r <= narrow_s;
      end
`ifdef FIR_SATURATE_EN
      sat_flag_r <= tree_valid_s & sat_s;
`endif
    end
  end

  assign strm.out_sample = out_sample_r;
  assign strm.out_valid  = out_valid_r;
`ifdef FIR_SATURATE_EN
  assign strm.sat_flag   = sat_flag_r;
`endif

endmodule

// File: tb/tb_fir_stream_filter.sv
// Scoreboard bench for fir_stream_filter: the driver pushes hand-computed
// expected outputs when it issues a sample; a negedge monitor pops and checks
// value, latency, hold-during-bubbles and (when built) sat_flag.
module tb_fir_stream_filter;

  localparam int LAT = 7;

  typedef struct {
    logic signed [31:0] val;
    logic               sat;
    int                 stamp;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               clr;
  logic               coef_we;
  logic [3:0]         coef_addr;
  logic signed [15:0] coef_data;

  int   checks = 0;
  int   errors = 0;
  int   ncount = 0;
  exp_t sbq [$];
  logic signed [31:0] last_out = 32'sd0;

  fir_stream_filter_if #(.DATA_W(32)) bus ();

  fir_stream_filter dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .strm      (bus)
  );

  always #5 clk = ~clk;

  // Monitor: every negedge either checks a presented output or checks the hold value.
  always @(negedge clk) begin : monitor
    exp_t e;
    ncount++;
    if (rst) begin
      last_out = 32'sd0;
    end else if (bus.out_valid) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %0d with no sample outstanding", bus.out_sample);
      end else begin
        e = sbq.pop_front();
        if (bus.out_sample !== e.val) begin
          errors++;
          $display("FAIL value: got %0d (0x%h) expected %0d (0x%h)",
                   bus.out_sample, bus.out_sample, e.val, e.val);
        end
        checks++;
        if (ncount - e.stamp != LAT) begin
          errors++;
          $display("FAIL latency: got %0d cycles expected %0d", ncount - e.stamp, LAT);
        end
`ifdef FIR_SATURATE_EN
        checks++;
        if (bus.sat_flag !== e.sat) begin
          errors++;
          $display("FAIL sat_flag: got %b expected %b", bus.sat_flag, e.sat);
        end
`endif
      end
      last_out = bus.out_sample;
    end else begin
      checks++;
      if (bus.out_sample !== last_out) begin
        errors++;
        $display("FAIL hold: got %0d expected %0d during bubble", bus.out_sample, last_out);
      end
`ifdef FIR_SATURATE_EN
      checks++;
      if (bus.sat_flag !== 1'b0) begin
        errors++;
        $display("FAIL sat_idle: got %b expected 0 while out_valid low", bus.sat_flag);
      end
`endif
    end
  end

  task automatic send(input logic signed [31:0] s, input logic signed [31:0] ev,
                      input logic es, input bit push, input bit with_clr);
    exp_t e;
    bus.in_valid  = 1'b1;
    bus.in_sample = s;
    clr           = with_clr;
    if (push) begin
      e.val   = ev;
      e.sat   = es;
      e.stamp = ncount + 1;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_sample = 32'sd999;
    clr           = 1'b0;
  endtask

  task automatic sendp(input logic signed [31:0] s, input logic signed [31:0] ev);
    send(s, ev, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic gap(input int n);
    bus.in_valid  = 1'b0;
    bus.in_sample = 32'sd999;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wcoef(input int addr, input logic signed [15:0] data);
    coef_we   = 1'b1;
    coef_addr = 4'(addr);
    coef_data = data;
    @(posedge clk); #1;
    coef_we   = 1'b0;
  endtask

  task automatic clear_line();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: got %0d outputs missing expected 0", name, sbq.size());
      sbq.delete();
    end
    gap(3);
  endtask

  initial begin
    rst           = 1'b1;
    clr           = 1'b0;
    coef_we       = 1'b0;
    coef_addr     = 4'd0;
    coef_data     = 16'sd0;
    bus.in_valid  = 1'b0;
    bus.in_sample = 32'sd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state.
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sample !== 32'sd0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b sample=%0d expected valid=0 sample=0",
               bus.out_valid, bus.out_sample);
    end

    // 1: default unit impulse passes samples through.
    sendp(32'sd5, 32'sd5);
    sendp(-32'sd7, -32'sd7);
    sendp(32'sd100, 32'sd100);
    drain("passthrough");

    // 2: four-tap moving average (0.25 each), step of 1000.
    wcoef(0, 16'sd4096);
    wcoef(1, 16'sd4096);
    wcoef(2, 16'sd4096);
    wcoef(3, 16'sd4096);
    clear_line();
    sendp(32'sd1000, 32'sd250);
    sendp(32'sd1000, 32'sd500);
    sendp(32'sd1000, 32'sd750);
    sendp(32'sd1000, 32'sd1000);
    sendp(32'sd1000, 32'sd1000);
    sendp(32'sd1000, 32'sd1000);
    drain("step");

    // 3: single tap at index 2 delays an impulse by two samples.
    wcoef(0, 16'sd0);
    wcoef(1, 16'sd0);
    wcoef(3, 16'sd0);
    wcoef(2, 16'sd16384);
    clear_line();
    sendp(32'sd1, 32'sd0);
    sendp(32'sd0, 32'sd0);
    sendp(32'sd0, 32'sd1);
    sendp(32'sd0, 32'sd0);
    sendp(32'sd0, 32'sd0);
    drain("tap_delay");

    // 4: pass-through with bubbles; garbage on in_sample while in_valid low.
    wcoef(2, 16'sd0);
    wcoef(0, 16'sd16384);
    sendp(32'sd11, 32'sd11);
    gap(1);
    sendp(-32'sd22, -32'sd22);
    gap(1);
    sendp(32'sd33, 32'sd33);
    gap(2);
    drain("bubbles");

    // 5: ten samples, then clr with a sample while tap 1 is selected.
    for (int i = 1; i <= 10; i++) begin
      sendp(32'(i), 32'(i));
    end
    drain("ten");
    wcoef(0, 16'sd0);
    wcoef(1, 16'sd16384);
    send(32'sd3, 32'sd0, 1'b0, 1'b1, 1'b1);
    sendp(32'sd4, 32'sd3);
    sendp(32'sd5, 32'sd4);
    send(32'sd6, 32'sd0, 1'b0, 1'b1, 1'b1);
    drain("clr");

    // 6: large gain on full-scale inputs.
    wcoef(1, 16'sd0);
    wcoef(0, 16'sd32767);
`ifdef FIR_SATURATE_EN
    send(32'sh7FFF_FFFF, 32'sh7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    send(32'sh8000_0000, 32'sh8000_0000, 1'b1, 1'b1, 1'b0);
`else
    send(32'sh7FFF_FFFF, 32'shFFFD_FFFE, 1'b0, 1'b1, 1'b0);
    send(32'sh8000_0000, 32'sh0002_0000, 1'b0, 1'b1, 1'b0);
`endif
    send(32'sd1000, 32'sd2000, 1'b0, 1'b1, 1'b0);
    drain("gain");

    // 7: reset mid-stream drops in-flight samples and overrides clr/coef_we.
    send(32'sd1, 32'sd0, 1'b0, 1'b0, 1'b0);
    send(32'sd2, 32'sd0, 1'b0, 1'b0, 1'b0);
    send(32'sd3, 32'sd0, 1'b0, 1'b0, 1'b0);
    rst       = 1'b1;
    clr       = 1'b1;
    coef_we   = 1'b1;
    coef_addr = 4'd0;
    coef_data = 16'sd5;
    @(posedge clk); #1;
    rst     = 1'b0;
    clr     = 1'b0;
    coef_we = 1'b0;
    gap(12);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_sample !== 32'sd0) begin
      errors++;
      $display("FAIL midstream_reset: got valid=%b sample=%0d expected valid=0 sample=0",
               bus.out_valid, bus.out_sample);
    end
    sendp(32'sd42, 32'sd42);
    drain("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound in case a wait above never completes.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
